// File: rtl/keypad_pkg.sv
// Shared types and hex legend for the debounced keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {
      NONE,
      SINGLE,
      MULTI
   } frame_class_t;

   typedef enum logic [1:0] {
      IDLE,
      CAND,
      PRESSED
   } state_t;

   // Entry i (LSB first) is the printed legend of key index i on a 4x4 pad.
   localparam logic [63:0] HEX_LEGEND = {
      4'hD, 4'hE, 4'hF, 4'h0,
      4'hC, 4'h9, 4'h8, 4'h7,
      4'hB, 4'h6, 4'h5, 4'h4,
      4'hA, 4'h3, 4'h2, 4'h1
   };

   function automatic logic [3:0] hex_of(input logic [3:0] idx);
      return HEX_LEGEND[{idx, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/keypad_col_driver.sv
// Column scan timer: one-cold column drive, row sample strobe, frame end strobe.
module keypad_col_driver #(
   parameter int NUM_COLS      = 4,
   parameter int COL_CYCLES    = 10,
   parameter int SETTLE_CYCLES = 3,
   parameter int IW            = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic [NUM_COLS-1:0] col,
   output logic [IW-1:0]       col_idx,
   output logic                sample,
   output logic                frame_end
);

   localparam int TW = (COL_CYCLES > 1) ? $clog2(COL_CYCLES) : 1;

   logic [TW-1:0] timer;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer   <= '0;
         col_idx <= '0;
         col     <= '1;
      end else begin
         if (timer == TW'(COL_CYCLES - 1)) begin
            timer   <= '0;
            col_idx <= (col_idx == IW'(NUM_COLS - 1)) ? '0 : col_idx + 1'b1;
         end else begin
            timer <= timer + 1'b1;
         end
         if (timer == '0)
            col <= ~(NUM_COLS'(1) << col_idx);
      end
   end

   assign sample    = (timer == TW'(SETTLE_CYCLES));
   assign frame_end = sample && (col_idx == IW'(NUM_COLS - 1));

endmodule

// File: rtl/keypad_scanner.sv
// Debounced matrix keypad scanner with multi-key rejection.
// Optional auto-repeat of key_valid when KEYPAD_REPEAT_EN is defined.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int NUM_ROWS        = 4,
   parameter int NUM_COLS        = 4,
   parameter int CLK_HZ          = 100000000,
   parameter int SCAN_HZ         = 1000,
   parameter int SETTLE_CYCLES   = 8,
   parameter int DEBOUNCE_FRAMES = 4,
   parameter int REPEAT_DELAY    = 500,
   parameter int REPEAT_PERIOD   = 100,
   parameter int KW = (NUM_ROWS * NUM_COLS > 1) ? $clog2(NUM_ROWS * NUM_COLS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_ROWS-1:0] row,
   output logic [NUM_COLS-1:0] col,
   output logic [KW-1:0]       key_code,
   output logic [3:0]          key_hex,
   output logic                key_valid,
   output logic                key_held,
   output logic                multi_key
);

   localparam int  COL_CYCLES = CLK_HZ / SCAN_HZ;
   localparam int  NK         = NUM_ROWS * NUM_COLS;
   localparam int  IW         = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam int  DW         = $clog2(DEBOUNCE_FRAMES + 1);
   localparam bit  IS_4X4     = (NUM_ROWS == 4) && (NUM_COLS == 4);

   if (COL_CYCLES <= SETTLE_CYCLES + 1) begin : g_bad_timing
      $error("column period too short for settle delay");
   end
   if (DEBOUNCE_FRAMES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_counts
      $error("frame counts must be at least 1");
   end

   logic [IW-1:0]       col_idx;
   logic                sample;
   logic                frame_end;
   logic [NUM_ROWS-1:0] row_s1;
   logic [NUM_ROWS-1:0] row_s2;
   logic [NK-1:0]       frame;
   logic                frame_done;

   keypad_col_driver #(
      .NUM_COLS      (NUM_COLS),
      .COL_CYCLES    (COL_CYCLES),
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .IW            (IW)
   ) u_col (
      .clk       (clk),
      .rst_n     (rst_n),
      .col       (col),
      .col_idx   (col_idx),
      .sample    (sample),
      .frame_end (frame_end)
   );

   // Frame bit [r*NUM_COLS+c] is 1 when the key is down.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_s1     <= '1;
         row_s2     <= '1;
         frame      <= '0;
         frame_done <= 1'b0;
      end else begin
         row_s1     <= row;
         row_s2     <= row_s1;
         frame_done <= frame_end;
         if (sample) begin
            for (int r = 0; r < NUM_ROWS; r++)
               frame[r * NUM_COLS + int'(col_idx)] <= ~row_s2[r];
         end
      end
   end

   frame_class_t cls;
   logic [KW-1:0] hit;

   always_comb begin
      cls = NONE;
      hit = '0;
      for (int i = 0; i < NK; i++) begin
         if (frame[i]) begin
            if (cls == NONE) begin
               cls = SINGLE;
               hit = KW'(i);
            end else begin
               cls = MULTI;
            end
         end
      end
   end

   state_t        state;
   logic [KW-1:0] cand;
   logic [DW-1:0] cnt;
   logic [DW-1:0] rel_cnt;
   logic          acc;
   logic          rep_fire;
   logic [3:0]    hit_hex;

   assign hit_hex = IS_4X4 ? hex_of(4'(hit)) : 4'h0;

   always_comb begin
      acc = 1'b0;
      if (frame_done && cls == SINGLE) begin
         if (state == IDLE)
            acc = (DEBOUNCE_FRAMES <= 1);
         else if (state == CAND)
            acc = (hit == cand) && (cnt >= DW'(DEBOUNCE_FRAMES - 1));
      end
   end

`ifdef KEYPAD_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);

   logic [RW-1:0] rep_cnt;
   logic [RW-1:0] rep_lim;
   logic          rep_first;
   logic          rep_hold;

   assign rep_lim  = rep_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD);
   assign rep_hold = frame_done && (state == PRESSED) &&
                     (cls == SINGLE) && (hit == key_code);
   assign rep_fire = rep_hold && (rep_cnt >= rep_lim - 1'b1);

   // rep_cnt counts held frames since the accept or the last repeat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt   <= '0;
         rep_first <= 1'b1;
      end else if (acc) begin
         rep_cnt   <= '0;
         rep_first <= 1'b1;
      end else if (frame_done && state == PRESSED) begin
         if (rep_fire) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
         end else if (rep_hold) begin
            rep_cnt <= rep_cnt + 1'b1;
         end else begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
         end
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cand      <= '0;
         cnt       <= '0;
         rel_cnt   <= '0;
         key_code  <= '0;
         key_hex   <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         multi_key <= 1'b0;
      end else begin
         key_valid <= acc || rep_fire;
         if (frame_done)
            multi_key <= (cls == MULTI);
         if (acc) begin
            state    <= PRESSED;
            key_code <= hit;
            key_hex  <= hit_hex;
            key_held <= 1'b1;
            rel_cnt  <= '0;
         end else if (frame_done) begin
            unique case (state)
               IDLE: begin
                  if (cls == SINGLE) begin
                     state <= CAND;
                     cand  <= hit;
                     cnt   <= DW'(1);
                  end
               end
               CAND: begin
                  if (cls != SINGLE) begin
                     state <= IDLE;
                  end else if (hit == cand) begin
                     cnt <= cnt + 1'b1;
                  end else begin
                     cand <= hit;
                     cnt  <= DW'(1);
                  end
               end
               PRESSED: begin
                  if (cls != NONE) begin
                     rel_cnt <= '0;
                  end else if (rel_cnt >= DW'(DEBOUNCE_FRAMES - 1)) begin
                     state    <= IDLE;
                     key_held <= 1'b0;
                     rel_cnt  <= '0;
                  end else begin
                     rel_cnt <= rel_cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
